// File: rtl/hpu_rob_cmt.sv
// Reorder-buffer completion tracking and in-order retire for the HPU pipeline.
// Allocates entries from ID, records ALU commit results, retires the head and raises mispredict redirects.
module hpu_rob_cmt #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned EXCP_W    = 4,
  localparam int unsigned IW       = $clog2(ROB_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_en_i,

  input  logic              id_rob__alloc_vld_i,
  input  logic [PC_W-1:0]   id_rob__alloc_pred_pc_i,
  output logic              rob_id__alloc_rdy_o,
  output logic [IW-1:0]     rob_id__alloc_index_o,
  output logic              rob_id__alloc_flag_o,
  output logic [IW:0]       rob_id__count_o,

  input  logic              alu0_rob__commit_en_i,
  input  logic              alu0_rob__commit_flag_i,
  input  logic [IW-1:0]     alu0_rob__commit_index_i,
  input  logic              alu0_rob__commit_excp_en_i,
  input  logic [EXCP_W-1:0] alu0_rob__commit_excp_i,
  input  logic              alu0_rob__commit_is_jbr_i,
  input  logic [PC_W-1:0]   alu0_rob__commit_next_pc_i,

  input  logic              alu1_rob__commit_en_i,
  input  logic              alu1_rob__commit_flag_i,
  input  logic [IW-1:0]     alu1_rob__commit_index_i,
  input  logic              alu1_rob__commit_excp_en_i,
  input  logic [EXCP_W-1:0] alu1_rob__commit_excp_i,
  input  logic              alu1_rob__commit_is_jbr_i,
  input  logic [PC_W-1:0]   alu1_rob__commit_next_pc_i,

  output logic              rob_ctrl__retire_en_o,
  output logic [IW-1:0]     rob_ctrl__retire_index_o,
  output logic              rob_ctrl__retire_excp_en_o,
  output logic [EXCP_W-1:0] rob_ctrl__retire_excp_o,
  output logic              rob_ctrl__redirect_en_o,
  output logic [PC_W-1:0]   rob_ctrl__redirect_pc_o
);

  // Pointers carry the wrap flag in their MSB so count is a plain subtraction.
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;

  logic [ROB_DEPTH-1:0] vld_q, vld_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [ROB_DEPTH-1:0] flag_q, flag_d;
  logic [ROB_DEPTH-1:0] excp_en_q, excp_en_d;
  logic [ROB_DEPTH-1:0] is_jbr_q, is_jbr_d;
  logic [EXCP_W-1:0]    excp_q    [ROB_DEPTH];
  logic [EXCP_W-1:0]    excp_d    [ROB_DEPTH];
  logic [PC_W-1:0]      pred_pc_q [ROB_DEPTH];
  logic [PC_W-1:0]      pred_pc_d [ROB_DEPTH];
  logic [PC_W-1:0]      next_pc_q [ROB_DEPTH];
  logic [PC_W-1:0]      next_pc_d [ROB_DEPTH];

  logic                 retire_en_q, retire_en_d;
  logic [IW-1:0]        retire_index_q, retire_index_d;
  logic                 retire_excp_en_q, retire_excp_en_d;
  logic [EXCP_W-1:0]    retire_excp_q, retire_excp_d;
  logic                 redirect_en_q, redirect_en_d;
  logic [PC_W-1:0]      redirect_pc_q, redirect_pc_d;

  logic [IW-1:0]        head_idx;
  logic [IW-1:0]        tail_idx;
  logic [PW-1:0]        count;
  logic                 full;
  logic                 pop;
  logic                 head_excp;
  logic                 head_mispred;
  logic                 kill;
  logic                 alloc_rdy;
  logic                 alloc_fire;
  logic                 c0_acc;
  logic                 c1_acc;

  // Head status, occupancy and commit acceptance.
  always_comb begin
    head_idx     = head_q[IW-1:0];
    tail_idx     = tail_q[IW-1:0];
    count        = tail_q - head_q;
    full         = (count == PW'(ROB_DEPTH));
    pop          = vld_q[head_idx] && done_q[head_idx];
    head_excp    = excp_en_q[head_idx];
    head_mispred = is_jbr_q[head_idx] && (next_pc_q[head_idx] != pred_pc_q[head_idx]);
    kill         = pop && (head_excp || head_mispred);
    alloc_rdy    = !full && !flush_en_i && !kill;
    alloc_fire   = id_rob__alloc_vld_i && alloc_rdy;

    c0_acc = alu0_rob__commit_en_i
          && vld_q[alu0_rob__commit_index_i]
          && !done_q[alu0_rob__commit_index_i]
          && (flag_q[alu0_rob__commit_index_i] == alu0_rob__commit_flag_i);
    // alu0 wins a same-index collision.
    c1_acc = alu1_rob__commit_en_i
          && vld_q[alu1_rob__commit_index_i]
          && !done_q[alu1_rob__commit_index_i]
          && (flag_q[alu1_rob__commit_index_i] == alu1_rob__commit_flag_i)
          && !(c0_acc && (alu0_rob__commit_index_i == alu1_rob__commit_index_i));
  end

  // Next state: commit, allocate, pop, then kill and flush override in that order.
  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    vld_d            = vld_q;
    done_d           = done_q;
    flag_d           = flag_q;
    excp_en_d        = excp_en_q;
    is_jbr_d         = is_jbr_q;
    excp_d           = excp_q;
    pred_pc_d        = pred_pc_q;
    next_pc_d        = next_pc_q;
    retire_en_d      = 1'b0;
    retire_index_d   = '0;
    retire_excp_en_d = 1'b0;
    retire_excp_d    = '0;
    redirect_en_d    = 1'b0;
    redirect_pc_d    = '0;

    if (c0_acc) begin
      done_d[alu0_rob__commit_index_i]    = 1'b1;
      excp_en_d[alu0_rob__commit_index_i] = alu0_rob__commit_excp_en_i;
      excp_d[alu0_rob__commit_index_i]    = alu0_rob__commit_excp_i;
      is_jbr_d[alu0_rob__commit_index_i]  = alu0_rob__commit_is_jbr_i;
      next_pc_d[alu0_rob__commit_index_i] = alu0_rob__commit_next_pc_i;
    end

    if (c1_acc) begin
      done_d[alu1_rob__commit_index_i]    = 1'b1;
      excp_en_d[alu1_rob__commit_index_i] = alu1_rob__commit_excp_en_i;
      excp_d[alu1_rob__commit_index_i]    = alu1_rob__commit_excp_i;
      is_jbr_d[alu1_rob__commit_index_i]  = alu1_rob__commit_is_jbr_i;
      next_pc_d[alu1_rob__commit_index_i] = alu1_rob__commit_next_pc_i;
    end

    if (alloc_fire) begin
      vld_d[tail_idx]     = 1'b1;
      done_d[tail_idx]    = 1'b0;
      flag_d[tail_idx]    = tail_q[IW];
      pred_pc_d[tail_idx] = id_rob__alloc_pred_pc_i;
      tail_d              = tail_q + PW'(1);
    end

    if (pop) begin
      vld_d[head_idx]  = 1'b0;
      head_d           = head_q + PW'(1);
      retire_en_d      = 1'b1;
      retire_index_d   = head_idx;
      retire_excp_en_d = head_excp;
      retire_excp_d    = head_excp ? excp_q[head_idx] : '0;
      redirect_en_d    = !head_excp && head_mispred;
      redirect_pc_d    = (!head_excp && head_mispred) ? next_pc_q[head_idx] : '0;
    end

    // Exception or mispredict squashes every younger entry.
    if (kill) begin
      vld_d  = '0;
      tail_d = head_d;
    end

    if (flush_en_i) begin
      vld_d            = '0;
      head_d           = '0;
      tail_d           = '0;
      retire_en_d      = 1'b0;
      retire_index_d   = '0;
      retire_excp_en_d = 1'b0;
      retire_excp_d    = '0;
      redirect_en_d    = 1'b0;
      redirect_pc_d    = '0;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q           <= '0;
      tail_q           <= '0;
      vld_q            <= '0;
      done_q           <= '0;
      retire_en_q      <= 1'b0;
      retire_index_q   <= '0;
      retire_excp_en_q <= 1'b0;
      retire_excp_q    <= '0;
      redirect_en_q    <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      vld_q            <= vld_d;
      done_q           <= done_d;
      retire_en_q      <= retire_en_d;
      retire_index_q   <= retire_index_d;
      retire_excp_en_q <= retire_excp_en_d;
      retire_excp_q    <= retire_excp_d;
      redirect_en_q    <= redirect_en_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Entry payload is qualified by vld, so it needs no reset.
  always_ff @(posedge clk_i) begin
    flag_q    <= flag_d;
    excp_en_q <= excp_en_d;
    is_jbr_q  <= is_jbr_d;
    excp_q    <= excp_d;
    pred_pc_q <= pred_pc_d;
    next_pc_q <= next_pc_d;
  end

  assign rob_id__alloc_rdy_o        = alloc_rdy;
  assign rob_id__alloc_index_o      = tail_idx;
  assign rob_id__alloc_flag_o       = tail_q[IW];
  assign rob_id__count_o            = count;
  assign rob_ctrl__retire_en_o      = retire_en_q;
  assign rob_ctrl__retire_index_o   = retire_index_q;
  assign rob_ctrl__retire_excp_en_o = retire_excp_en_q;
  assign rob_ctrl__retire_excp_o    = retire_excp_q;
  assign rob_ctrl__redirect_en_o    = redirect_en_q;
  assign rob_ctrl__redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_hpu_rob_cmt.sv
// Scoreboard bench for hpu_rob_cmt: a queue-based program-order ROB model predicts
// retire/redirect events, and a monitor checks them as the DUT presents them.
module tb_hpu_rob_cmt;

  localparam int D      = 16;
  localparam int IW     = 4;
  localparam int PC_W   = 32;
  localparam int EXCP_W = 4;

  typedef struct {
    bit              en;
    bit              flag;
    logic [IW-1:0]   idx;
    bit              xe;
    logic [EXCP_W-1:0] xc;
    bit              jbr;
    logic [PC_W-1:0] npc;
  } cmt_t;

  typedef struct {
    bit              done;
    bit              xe;
    logic [EXCP_W-1:0] xc;
    bit              jbr;
    logic [PC_W-1:0] ppc;
    logic [PC_W-1:0] npc;
  } ent_t;

  typedef struct {
    logic [IW-1:0]   idx;
    bit              xe;
    logic [EXCP_W-1:0] xc;
    bit              redir;
    logic [PC_W-1:0] rpc;
    int              due;
  } ret_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_en = 1'b0;
  logic alloc_vld = 1'b0;
  logic [PC_W-1:0] alloc_pc = '0;
  logic rdy;
  logic [IW-1:0] aidx;
  logic aflag;
  logic [IW:0] cnt;
  logic a0_en = 1'b0, a0_flag = 1'b0, a0_xe = 1'b0, a0_jbr = 1'b0;
  logic [IW-1:0] a0_idx = '0;
  logic [EXCP_W-1:0] a0_xc = '0;
  logic [PC_W-1:0] a0_npc = '0;
  logic a1_en = 1'b0, a1_flag = 1'b0, a1_xe = 1'b0, a1_jbr = 1'b0;
  logic [IW-1:0] a1_idx = '0;
  logic [EXCP_W-1:0] a1_xc = '0;
  logic [PC_W-1:0] a1_npc = '0;
  logic ret_en, ret_xe, redir_en;
  logic [IW-1:0] ret_idx;
  logic [EXCP_W-1:0] ret_xc;
  logic [PC_W-1:0] redir_pc;

  ent_t rob[$];
  ret_t exp_q[$];
  ret_t mon_r;
  int   head_ptr = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  hpu_rob_cmt #(.ROB_DEPTH(D), .PC_W(PC_W), .EXCP_W(EXCP_W)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst_i),
    .flush_en_i                 (flush_en),
    .id_rob__alloc_vld_i        (alloc_vld),
    .id_rob__alloc_pred_pc_i    (alloc_pc),
    .rob_id__alloc_rdy_o        (rdy),
    .rob_id__alloc_index_o      (aidx),
    .rob_id__alloc_flag_o       (aflag),
    .rob_id__count_o            (cnt),
    .alu0_rob__commit_en_i      (a0_en),
    .alu0_rob__commit_flag_i    (a0_flag),
    .alu0_rob__commit_index_i   (a0_idx),
    .alu0_rob__commit_excp_en_i (a0_xe),
    .alu0_rob__commit_excp_i    (a0_xc),
    .alu0_rob__commit_is_jbr_i  (a0_jbr),
    .alu0_rob__commit_next_pc_i (a0_npc),
    .alu1_rob__commit_en_i      (a1_en),
    .alu1_rob__commit_flag_i    (a1_flag),
    .alu1_rob__commit_index_i   (a1_idx),
    .alu1_rob__commit_excp_en_i (a1_xe),
    .alu1_rob__commit_excp_i    (a1_xc),
    .alu1_rob__commit_is_jbr_i  (a1_jbr),
    .alu1_rob__commit_next_pc_i (a1_npc),
    .rob_ctrl__retire_en_o      (ret_en),
    .rob_ctrl__retire_index_o   (ret_idx),
    .rob_ctrl__retire_excp_en_o (ret_xe),
    .rob_ctrl__retire_excp_o    (ret_xc),
    .rob_ctrl__redirect_en_o    (redir_en),
    .rob_ctrl__redirect_pc_o    (redir_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int pptr(input int p);
    return (head_ptr + p) % (2 * D);
  endfunction

  function automatic int tail_ptr();
    return pptr(rob.size());
  endfunction

  function automatic bit head_kill();
    if (rob.size() == 0) return 1'b0;
    if (!rob[0].done) return 1'b0;
    return rob[0].xe || (rob[0].jbr && (rob[0].npc != rob[0].ppc));
  endfunction

  function automatic bit exp_rdy(input bit fl);
    return !fl && (rob.size() < D) && !head_kill();
  endfunction

  // Position of the live, not-yet-done entry a commit names, or -1.
  function automatic int find(input cmt_t c);
    int key;
    int p;
    key = (c.flag ? D : 0) + int'(c.idx);
    p = (key - head_ptr + 2 * D) % (2 * D);
    if (!c.en || p >= rob.size()) return -1;
    if (rob[p].done) return -1;
    return p;
  endfunction

  task automatic apply(input int p, input cmt_t c);
    ent_t e;
    e = rob[p];
    e.done = 1'b1;
    e.xe   = c.xe;
    e.xc   = c.xc;
    e.jbr  = c.jbr;
    e.npc  = c.npc;
    rob[p] = e;
  endtask

  task automatic model_step(input bit fl, input bit av, input logic [PC_W-1:0] pc,
                            input cmt_t c0, input cmt_t c1);
    bit pop, kill, ok;
    int p0, p1;
    ent_t e, h;
    ret_t r;
    if (fl) begin
      rob.delete();
      head_ptr = 0;
      return;
    end
    pop  = (rob.size() > 0) && rob[0].done;
    kill = head_kill();
    ok   = exp_rdy(1'b0);
    p0 = find(c0);
    p1 = find(c1);
    if (p0 >= 0 && c1.idx == c0.idx) p1 = -1;
    if (p0 >= 0) apply(p0, c0);
    if (p1 >= 0) apply(p1, c1);
    if (av && ok) begin
      e.done = 1'b0; e.xe = 1'b0; e.xc = '0; e.jbr = 1'b0; e.ppc = pc; e.npc = '0;
      rob.push_back(e);
    end
    if (pop) begin
      h = rob[0];
      r.idx   = IW'(head_ptr % D);
      r.xe    = h.xe;
      r.xc    = h.xc;
      r.redir = !h.xe && h.jbr && (h.npc != h.ppc);
      r.rpc   = h.npc;
      r.due   = cyc + 1;
      exp_q.push_back(r);
      rob.delete(0);
      head_ptr = (head_ptr + 1) % (2 * D);
      if (kill) rob.delete();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic cmt_t mk(input bit en, input int fl, input int idx, input bit xe,
                              input int xc, input bit jbr, input int npc);
    cmt_t c;
    c.en = en; c.flag = fl[0]; c.idx = IW'(idx); c.xe = xe;
    c.xc = EXCP_W'(xc); c.jbr = jbr; c.npc = PC_W'(npc);
    return c;
  endfunction

  function automatic cmt_t nc();
    return mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 0);
  endfunction

  function automatic cmt_t rnd_cmt();
    cmt_t c;
    int p;
    c = nc();
    if (rob.size() == 0 || $urandom_range(0, 99) < 40) return c;
    p = $urandom_range(0, rob.size() - 1);
    c = mk(1'b1, pptr(p) / D, pptr(p) % D, $urandom_range(0, 99) < 4, $urandom_range(0, 15),
           $urandom_range(0, 99) < 30, $urandom_range(0, 3) * 4);
    if ($urandom_range(0, 99) < 10) c.flag = !c.flag;
    return c;
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, advance the model.
  task automatic step(input bit fl, input bit av, input logic [PC_W-1:0] pc,
                      input cmt_t c0, input cmt_t c1);
    @(negedge clk);
    #2;
    flush_en = fl; alloc_vld = av; alloc_pc = pc;
    a0_en = c0.en; a0_flag = c0.flag; a0_idx = c0.idx; a0_xe = c0.xe;
    a0_xc = c0.xc; a0_jbr = c0.jbr; a0_npc = c0.npc;
    a1_en = c1.en; a1_flag = c1.flag; a1_idx = c1.idx; a1_xe = c1.xe;
    a1_xc = c1.xc; a1_jbr = c1.jbr; a1_npc = c1.npc;
    #1;
    chk("alloc_rdy",   64'(rdy),   64'(exp_rdy(fl)));
    chk("alloc_index", 64'(aidx),  64'(tail_ptr() % D));
    chk("alloc_flag",  64'(aflag), 64'(tail_ptr() / D));
    chk("count",       64'(cnt),   64'(rob.size()));
    model_step(fl, av, pc, c0, c1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, nc(), nc());
  endtask

  task automatic alloc_n(input int n);
    repeat (n) step(1'b0, 1'b1, PC_W'($urandom_range(0, 3) * 4), nc(), nc());
  endtask

  task automatic do_flush();
    step(1'b1, 1'b0, '0, nc(), nc());
  endtask

  // Commit every outstanding entry, two per cycle, with no exception or branch.
  task automatic drain();
    cmt_t c [2];
    int n;
    for (int k = 0; k < 4 * D && rob.size() > 0; k++) begin
      c[0] = nc(); c[1] = nc(); n = 0;
      for (int p = 0; p < rob.size() && n < 2; p++) begin
        if (!rob[p].done) begin
          c[n] = mk(1'b1, pptr(p) / D, pptr(p) % D, 1'b0, 0, 1'b0, 0);
          n++;
        end
      end
      step(1'b0, 1'b0, '0, c[0], c[1]);
    end
    idle(2);
    chk("drain_count", 64'(cnt), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    exp_q.delete();
    rst_i = 1'b1;
    flush_en = 1'b0; alloc_vld = 1'b0; a0_en = 1'b0; a1_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_retire_en",   64'(ret_en),   64'd0);
    chk("rst_retire_idx",  64'(ret_idx),  64'd0);
    chk("rst_retire_xe",   64'(ret_xe),   64'd0);
    chk("rst_redirect_en", 64'(redir_en), 64'd0);
    chk("rst_redirect_pc", 64'(redir_pc), 64'd0);
    rst_i = 1'b0;
    rob.delete();
    head_ptr = 0;
    #1;
    chk("rst_rdy",   64'(rdy),  64'd1);
    chk("rst_count", 64'(cnt),  64'd0);
    chk("rst_index", 64'(aidx), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL retire_missing: index %0d due cycle %0d not seen by cycle %0d",
                 exp_q[0].idx, exp_q[0].due, cyc);
        exp_q.delete(0);
      end
      if (ret_en) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL retire_unexpected: got index %0h expected no retire (cycle %0d)", ret_idx, cyc);
        end else begin
          mon_r = exp_q[0];
          exp_q.delete(0);
          chk("retire_index",   64'(ret_idx),  64'(mon_r.idx));
          chk("retire_excp_en", 64'(ret_xe),   64'(mon_r.xe));
          if (mon_r.xe) chk("retire_excp", 64'(ret_xc), 64'(mon_r.xc));
          chk("redirect_en",    64'(redir_en), 64'(mon_r.redir));
          if (mon_r.redir) chk("redirect_pc", 64'(redir_pc), 64'(mon_r.rpc));
        end
      end else begin
        chk("redirect_idle", 64'(redir_en), 64'd0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    do_reset();

    // Fill to capacity, then wrap the tail after one retire.
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, PC_W'(i * 4), nc(), nc());
      chk("fill_index", 64'(aidx), 64'(i));
      chk("fill_flag",  64'(aflag), 64'd0);
    end
    step(1'b0, 1'b1, '0, nc(), nc());
    chk("full_rdy",   64'(rdy), 64'd0);
    chk("full_count", 64'(cnt), 64'd16);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 0, 1'b0, 0, 1'b0, 0), nc());
    idle(1);
    step(1'b0, 1'b1, 32'h44, nc(), nc());
    chk("wrap_index", 64'(aidx), 64'd0);
    chk("wrap_flag",  64'(aflag), 64'd1);
    chk("wrap_count", 64'(cnt), 64'd15);
    drain();

    // Out-of-order completion retires in order.
    do_flush();
    alloc_n(3);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 2, 1'b0, 0, 1'b0, 0), nc());
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 0, 1'b0, 0, 1'b0, 0), nc());
    step(1'b0, 1'b0, '0, nc(), mk(1'b1, 0, 1, 1'b0, 0, 1'b0, 0));
    idle(4);

    // Stale-flag commit is ignored.
    do_flush();
    alloc_n(D);
    drain();
    alloc_n(4);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 3, 1'b0, 0, 1'b0, 0), nc());
    step(1'b0, 1'b0, '0, mk(1'b1, 1, 0, 1'b0, 0, 1'b0, 0), mk(1'b1, 1, 1, 1'b0, 0, 1'b0, 0));
    step(1'b0, 1'b0, '0, mk(1'b1, 1, 2, 1'b0, 0, 1'b0, 0), nc());
    idle(4);
    chk("stale_count", 64'(cnt), 64'd1);
    step(1'b0, 1'b0, '0, mk(1'b1, 1, 3, 1'b0, 0, 1'b0, 0), nc());
    idle(3);
    chk("stale_done_count", 64'(cnt), 64'd0);

    // Mispredict on entry 1 squashes the rest.
    do_flush();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 1) ? 32'h100 : 32'h40, nc(), nc());
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 1, 1'b0, 0, 1'b1, 32'h200), mk(1'b1, 0, 0, 1'b0, 0, 1'b0, 0));
    idle(2);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 2, 1'b0, 0, 1'b0, 0), mk(1'b1, 0, 3, 1'b0, 0, 1'b0, 0));
    chk("mispred_count", 64'(cnt), 64'd0);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 4, 1'b0, 0, 1'b0, 0), nc());
    idle(3);

    // Same-index collision: alu0 data kept, alu1 exception dropped.
    do_flush();
    alloc_n(1);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 0, 1'b0, 0, 1'b0, 0), mk(1'b1, 0, 0, 1'b1, 2, 1'b0, 0));
    idle(3);

    // Exception on the head squashes younger entries.
    alloc_n(3);
    step(1'b0, 1'b0, '0, mk(1'b1, 0, 1, 1'b1, 9, 1'b0, 0), mk(1'b1, 0, 2, 1'b0, 0, 1'b0, 0));
    idle(3);
    chk("excp_count", 64'(cnt), 64'd0);

    // Flush with live entries, a same-cycle alloc and a pending commit.
    do_flush();
    alloc_n(6);
    step(1'b1, 1'b1, 32'h8, mk(1'b1, 0, 2, 1'b0, 0, 1'b0, 0), nc());
    chk("flush_rdy", 64'(rdy), 64'd0);
    idle(1);
    chk("flush_count", 64'(cnt), 64'd0);
    chk("flush_index", 64'(aidx), 64'd0);
    idle(3);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 65,
           PC_W'($urandom_range(0, 3) * 4), rnd_cmt(), rnd_cmt());
    end

    // Reset with live state, then a short burst.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      step(1'b0, $urandom_range(0, 99) < 65, PC_W'($urandom_range(0, 3) * 4), rnd_cmt(), rnd_cmt());
    end
    drain();
    idle(4);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
